// File: rtl/mips32_fetch_unit.sv
// MIPS32 instruction fetch: req/ack imem reader feeding a prefetch queue
// that decode drains over valid/ready. A redirect flushes the queue.
module mips32_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [29:0]   drop_addr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] after_push;
  logic          push;
  logic          pop;

  assign imem_req    = (state == S_REQ) || (state == S_DROP);
  assign imem_addr   = (state == S_DROP) ? drop_addr : fetch_pc[31:2];
  assign instr_valid = (count != '0);
  assign instr       = q_instr[head];
  assign instr_pc    = q_pc[head];

  assign push       = (state == S_REQ) && imem_ack && !redirect;
  assign pop        = instr_valid && instr_ready;
  assign after_push = count + CW'(1) - CW'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata;
        q_pc[tail]    <= fetch_pc;
      end
      if (redirect) begin
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        // An unacked request must still be drained at its old address
        unique case (1'b1)
          (state == S_REQ): begin
            if (!imem_ack) begin
              state     <= S_DROP;
              drop_addr <= fetch_pc[31:2];
            end else begin
              state <= S_REQ;
            end
          end
          (state == S_DROP): state <= imem_ack ? S_REQ : S_DROP;
          default:           state <= S_REQ;
        endcase
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        unique case (1'b1)
          (state == S_IDLE): begin
            if (count < CW'(DEPTH)) state <= S_REQ;
          end
          (state == S_REQ): begin
            if (imem_ack) begin
              fetch_pc <= fetch_pc + 32'd4;
              state    <= (after_push < CW'(DEPTH)) ? S_REQ : S_IDLE;
            end
          end
          (state == S_DROP): begin
            if (imem_ack) state <= S_REQ;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
